// File: rtl/pcm_frame_rx.sv
// pcm_frame_rx: I2S frame receiver for the 8.192 MHz domain. Assembles
// left/right words from a looped-back 256 kHz bit clock and publishes pairs.
module pcm_frame_rx #(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_8_192_MHz,
  input  logic              reset_n,
  input  logic              sclk_in,
  input  logic              ws_in,
  input  logic              sd_in,
  output logic [WORD_W-1:0] left_data,
  output logic [WORD_W-1:0] right_data,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam logic [4:0] WORD_LEN = 5'(WORD_W);
  localparam logic [4:0] CNT_MAX  = 5'd31;

  typedef enum logic [1:0] {
    HUNT,
    LEFT,
    RIGHT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sclk_dly;

  logic                   sclk_s;
  logic                   ws_s;
  logic                   sd_s;
  logic                   bit_edge;

  // Only WORD_W-1 bits are stored; the freshly sampled bit completes the word.
  logic [WORD_W-2:0]      shreg;
  logic [WORD_W-1:0]      shreg_next;
  logic [WORD_W-1:0]      left_hold;
  logic [4:0]             bit_cnt;
  logic [4:0]             cnt_inc;
  logic                   ws_prev;

  logic                   transition;
  logic                   ws_fall;
  logic                   len_ok;
  logic                   load_left;
  logic                   publish;
  logic                   word_err;

  always_ff @(posedge clk_8_192_MHz) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
      sclk_dly  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], ws_in};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd_in};
      sclk_dly  <= sclk_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s     = sclk_sync[SYNC_STAGES-1];
    ws_s       = ws_sync[SYNC_STAGES-1];
    sd_s       = sd_sync[SYNC_STAGES-1];
    bit_edge   = sclk_s & ~sclk_dly;
    shreg_next = {shreg, sd_s};
    cnt_inc    = (bit_cnt == CNT_MAX) ? CNT_MAX : bit_cnt + 5'd1;
    len_ok     = (cnt_inc == WORD_LEN);
    transition = bit_edge & (ws_s ^ ws_prev);
    ws_fall    = transition & ws_prev;
  end

  always_ff @(posedge clk_8_192_MHz) begin
    if (!reset_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_left = 1'b0;
    publish   = 1'b0;
    word_err  = 1'b0;
    case (state_q)
      HUNT: begin
        if (ws_fall) begin
          state_d = LEFT;
        end
      end
      LEFT: begin
        if (transition) begin
          if (len_ok) begin
            load_left = 1'b1;
            state_d   = RIGHT;
          end else begin
            word_err = 1'b1;
            state_d  = HUNT;
          end
        end
      end
      RIGHT: begin
        if (transition) begin
          if (len_ok) begin
            publish = 1'b1;
          end else begin
            word_err = 1'b1;
          end
          state_d = LEFT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_8_192_MHz) begin
    if (!reset_n) begin
      shreg     <= '0;
      left_hold <= '0;
      bit_cnt   <= '0;
      ws_prev   <= 1'b0;
    end else if (bit_edge) begin
      shreg   <= shreg_next[WORD_W-2:0];
      ws_prev <= ws_s;
      bit_cnt <= transition ? 5'd0 : cnt_inc;
      if (load_left) begin
        left_hold <= shreg_next;
      end
    end
  end

  // A publish while the previous pair is still pending and not being taken
  // this cycle is the only overrun case.
  always_ff @(posedge clk_8_192_MHz) begin
    if (!reset_n) begin
      left_data   <= '0;
      right_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      overrun   <= publish & frame_valid & ~frame_ready;
      frame_err <= word_err;
      if (publish) begin
        left_data   <= left_hold;
        right_data  <= shreg_next;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcm_frame_rx.sv
// Directed bench for pcm_frame_rx: drives I2S frames at 32 system clocks per
// bit and checks published pairs, handshake, overrun and word-length errors.
`timescale 1ns/1ps
module tb_pcm_frame_rx;

  localparam int unsigned W = 16;

  logic         clk_8_192_MHz = 1'b0;
  logic         reset_n       = 1'b0;
  logic         sclk_in       = 1'b1;
  logic         ws_in         = 1'b0;
  logic         sd_in         = 1'b0;
  logic         frame_ready   = 1'b1;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         frame_valid;
  logic         overrun;
  logic         frame_err;

  pcm_frame_rx #(.WORD_W(W), .SYNC_STAGES(2)) dut (
    .clk_8_192_MHz (clk_8_192_MHz),
    .reset_n       (reset_n),
    .sclk_in       (sclk_in),
    .ws_in         (ws_in),
    .sd_in         (sd_in),
    .left_data     (left_data),
    .right_data    (right_data),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .overrun       (overrun),
    .frame_err     (frame_err)
  );

  always #61 clk_8_192_MHz = ~clk_8_192_MHz;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: event counters sampled on the falling edge.
  int unsigned cyc         = 0;
  int unsigned pubs        = 0;
  int unsigned fv_cycles   = 0;
  int unsigned ov_cnt      = 0;
  int unsigned err_cnt     = 0;
  int unsigned both_cnt    = 0;
  int unsigned fv_rise_cyc = 0;
  int unsigned rise_cyc    = 0;
  logic        fv_prev     = 1'b0;

  always @(posedge clk_8_192_MHz) cyc <= cyc + 1;

  always @(negedge clk_8_192_MHz) begin
    if (frame_valid === 1'b1) begin
      fv_cycles++;
      if (fv_prev !== 1'b1) begin
        pubs++;
        fv_rise_cyc = cyc;
      end
    end
    if (overrun === 1'b1) ov_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (overrun === 1'b1 && frame_err === 1'b1) both_cnt++;
    fv_prev = frame_valid;
  end

  task automatic wait_neg(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk_8_192_MHz);
  endtask

  // One bit: 16 clocks low (data changes), 16 clocks high. Optional
  // single-cycle reset pulse in the middle of the low phase.
  task automatic send_bit(input logic ws, input logic sd, input logic do_rst);
    @(negedge clk_8_192_MHz);
    sclk_in = 1'b0;
    ws_in   = ws;
    sd_in   = sd;
    if (do_rst) begin
      wait_neg(7);
      reset_n = 1'b0;
      @(negedge clk_8_192_MHz);
      check("rst_mid_clear", {left_data, right_data, frame_valid, overrun, frame_err}, '0);
      reset_n = 1'b1;
      wait_neg(8);
    end else begin
      wait_neg(16);
    end
    sclk_in  = 1'b1;
    rise_cyc = cyc;
    wait_neg(15);
  endtask

  // I2S word: MSB..LSB+1 with this word's ws, LSB with the next word's ws.
  task automatic send_word(input logic ws, input logic [31:0] data, input int len,
                           input logic next_ws, input int rst_bit);
    for (int i = len - 1; i >= 1; i--) send_bit(ws, data[i], (len - i) == rst_bit);
    send_bit(next_ws, data[0], 1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    send_word(1'b0, {16'h0, l}, 16, 1'b1, -1);
    send_word(1'b1, {16'h0, r}, 16, 1'b0, -1);
  endtask

  int unsigned p0, f0, o0, e0;
  task automatic snap();
    p0 = pubs; f0 = fv_cycles; o0 = ov_cnt; e0 = err_cnt;
  endtask

  initial begin
    #(122 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held for 5 cycles with inputs toggling.
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_8_192_MHz);
      check("reset_outputs", {left_data, right_data, frame_valid, overrun, frame_err}, '0);
      sclk_in = ~sclk_in;
      ws_in   = ~ws_in;
      sd_in   = 1'($urandom_range(0, 1));
    end
    check("reset_pulses", {32'(ov_cnt), 32'(err_cnt)}, '0);
    @(negedge clk_8_192_MHz);
    reset_n = 1'b1;
    sclk_in = 1'b1;
    ws_in   = 1'b0;
    sd_in   = 1'b0;
    snap();
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0);
    check("idle_no_valid", {32'(pubs - p0), 31'd0, frame_valid}, '0);

    // Normal reception, ready held high.
    frame_ready = 1'b1;
    snap();
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_frame(16'hA5C3, 16'h1234);
    send_frame(16'hA5C3, 16'h1234);
    check("norm_pubs", pubs - p0, 2);
    check("norm_fv_cycles", fv_cycles - f0, 2);
    check("norm_left", left_data, 16'hA5C3);
    check("norm_right", right_data, 16'h1234);
    check("norm_no_ovr_err", {32'(ov_cnt - o0), 32'(err_cnt - e0)}, '0);
    // Cycle in which sclk rose counts as cycle 1; valid shows in cycle 4.
    check("norm_latency", fv_rise_cyc - rise_cyc + 1, 4);

    // Backpressure: three frames without acceptance.
    frame_ready = 1'b0;
    snap();
    send_frame(16'h0001, 16'h0002);
    send_frame(16'h0003, 16'h0004);
    send_frame(16'h0005, 16'h0006);
    check("bp_overrun", ov_cnt - o0, 2);
    check("bp_pubs", pubs - p0, 1);
    check("bp_valid_held", frame_valid, 1'b1);
    check("bp_left", left_data, 16'h0005);
    check("bp_right", right_data, 16'h0006);
    check("bp_no_err", err_cnt - e0, 0);
    frame_ready = 1'b1;
    @(negedge clk_8_192_MHz);
    check("bp_valid_clear", frame_valid, 1'b0);

    // Short (15-bit) left word, then a right word, then a good frame.
    snap();
    send_word(1'b0, 32'h0000_7ABC, 15, 1'b1, -1);
    send_word(1'b1, 32'h0000_0BAD, 16, 1'b0, -1);
    check("short_err", err_cnt - e0, 1);
    check("short_no_pub", pubs - p0, 0);
    send_frame(16'h1111, 16'h2222);
    check("short_recover_pubs", pubs - p0, 1);
    check("short_recover_data", {left_data, right_data}, 32'h1111_2222);

    // Long (17-bit) right word; next frame follows immediately.
    snap();
    send_word(1'b0, 32'h0000_3333, 16, 1'b1, -1);
    send_word(1'b1, 32'h0001_ABCD, 17, 1'b0, -1);
    check("long_err", err_cnt - e0, 1);
    check("long_no_pub", pubs - p0, 0);
    send_frame(16'h4444, 16'h5555);
    check("long_recover_pubs", pubs - p0, 1);
    check("long_recover_data", {left_data, right_data}, 32'h4444_5555);

    // Reset pulse during the 8th bit of a left word.
    snap();
    send_word(1'b0, 32'h0000_DEAD, 16, 1'b1, 8);
    send_word(1'b1, 32'h0000_BEEF, 16, 1'b0, -1);
    check("rst_no_pub", pubs - p0, 0);
    check("rst_no_err", err_cnt - e0, 0);
    send_frame(16'h6666, 16'h7777);
    check("rst_recover_pubs", pubs - p0, 1);
    check("rst_recover_data", {left_data, right_data}, 32'h6666_7777);
    check("rst_recover_no_err", err_cnt - e0, 0);

    check("ovr_err_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
